pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Consumes the per-instruction control bundle from the single-cycle control decoder in ID.
//  Carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
//  Detects load-use hazards (stall plus bubble) and resolves beq/bne/j in EX (flush).
//  Generates EX-stage operand forwarding selects for the 5-stage pipelined MIPS datapath.
// PARAMETERS
//  REG_W     5  register-address width
//  ALUOP_W   2  ALUOp width
//  LU_STALL  1  1 = load-use stall enabled; 0 = never stall (test/debug only)
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous active-high reset
//  id_valid    in   1        ID holds a real instruction; 0 = treat as bubble
//  id_rs       in   REG_W    instr[25:21]
//  id_rt       in   REG_W    instr[20:16]
//  id_rd       in   REG_W    instr[15:11]
//  id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
//  id_Branch, id_Bne, id_Jump  in  1 each  decoder outputs
//  id_ALUOp    in   ALUOP_W  decoder ALUOp
//  ex_zero     in   1        ALU zero flag of the instruction in EX
//  pc_write    out  1        PC load enable
//  ifid_write  out  1        IF/ID load enable
//  ifid_flush  out  1        clear IF/ID at next edge
//  pc_src      out  1        select branch/jump target (valid when ifid_flush=1)
//  pc_jump     out  1        target is the jump address, not the branch address
//  ex_ALUSrc   out  1        registered ID/EX control
//  ex_ALUOp    out  ALUOP_W  registered ID/EX control
//  ex_wreg     out  REG_W    EX destination register
//  fwd_a       out  2        rs operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b       out  2        rt operand select, same encoding as fwd_a
//  mem_MemRead, mem_MemWrite  out  1 each  EX/MEM control
//  wb_RegWrite, wb_MemtoReg   out  1 each  MEM/WB control
//  wb_wreg     out  REG_W    write-back destination register
// BEHAVIOUR
//  - Reset: all stage registers are cleared at the first clock edge with rst=1.
//    Registered outputs go to 0; fwd_a=fwd_b=00, pc_write=ifid_write=1, flush/pc_src/pc_jump=0.
//  - Destination register: wreg = RegDst ? rd : rt, computed in ID and captured into ID/EX.
//    Register 0 is never a forwarding or stall source.
//  - Pipeline: each edge ID/EX<-ID, EX/MEM<-ID/EX, MEM/WB<-EX/MEM.
//    A bubble is the all-zero control bundle with wreg=0.
//  - Load-use: stall = LU_STALL & ex_MemRead & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt).
//    The match is checked regardless of whether the ID instruction actually reads rt.
//    On stall: pc_write=0, ifid_write=0, bubble into ID/EX; EX/MEM and MEM/WB advance.
//    The stall lasts exactly 1 cycle.
//  - Branch in EX: take = ex_Jump | (ex_Branch & ex_zero) | (ex_Bne & ~ex_zero).
//    On take: pc_src=1, pc_jump=ex_Jump, ifid_flush=1, bubble into ID/EX.
//    The two squashed instructions never write the regfile or memory.
//  - Simultaneous take and stall: take wins (pc_write=1, ifid_write=1, flush=1).
//  - id_valid=0: bubble into ID/EX; no stall is asserted.
//  - Forwarding (combinational from registered state):
//    fwd_a=10 if mem_RegWrite & mem_wreg!=0 & mem_wreg==ex_rs;
//    else 01 if wb_RegWrite & wb_wreg!=0 & wb_wreg==ex_rs; else 00.
//    fwd_b uses the same rule with ex_rt. EX/MEM takes priority over MEM/WB.
//  - Reset mid-stall or mid-flush: all stages become bubbles at that edge.
//    The stall or flush is not resumed.
//  - Latency: controls appear at ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after ID capture.
// TESTING
//  1. rst=1 for 2 cycles -> every registered output 0; pc_write=ifid_write=1; fwd_a=fwd_b=00.
//  2. lw $8 then add $9,$8,$10 -> 1 stall cycle; pc_write=0, ex_* all 0.
//     Next cycle fwd_a=01 (wb_wreg=8).
//  3. add $8,$1,$2 then sub $9,$8,$8 -> no stall; fwd_a=fwd_b=10 while sub is in EX.
//  4. beq with ex_zero=1 -> pc_src=1, pc_jump=0, ifid_flush=1, bubble in ID/EX.
//     With ex_zero=0 -> no flush. bne: the same cases with ex_zero inverted.
//  5. j (Branch=1, Jump=1) with ex_zero=0 -> take: pc_jump=1, flush=1.
//     A simultaneous load-use match in ID -> pc_write=1, no stall.
//  6. add $0,$1,$2 then add $3,$0,$0 -> fwd 00.
//     Assert rst during a stall cycle -> next cycle all stages are bubbles and pc_write=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Control pipeline for the 5-stage MIPS datapath. It carries the decoder bundle
// through ID/EX, EX/MEM and MEM/WB, and handles load-use stalls, EX branch flushes and forwarding.
module pipe_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 2,
    parameter int LU_STALL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_RegDst,
    input  logic               id_ALUSrc,
    input  logic               id_MemtoReg,
    input  logic               id_RegWrite,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_Branch,
    input  logic               id_Bne,
    input  logic               id_Jump,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               ex_zero,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               pc_src,
    output logic               pc_jump,
    output logic               ex_ALUSrc,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [REG_W-1:0]   ex_wreg,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic               wb_RegWrite,
    output logic               wb_MemtoReg,
    output logic [REG_W-1:0]   wb_wreg
);

    // ID/EX control bundle; RegDst is consumed in ID when forming the destination.
    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic               bne;
        logic               jump;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   wreg;
    } idex_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memread;
        logic             memwrite;
        logic [REG_W-1:0] wreg;
    } exmem_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] wreg;
    } memwb_t;

    idex_t  id_b, ex_q;
    exmem_t mem_q;
    memwb_t wb_q;

    logic take, lu_hit, stall, bubble;

    always_comb begin
        id_b          = '0;
        id_b.alusrc   = id_ALUSrc;
        id_b.aluop    = id_ALUOp;
        id_b.memtoreg = id_MemtoReg;
        id_b.regwrite = id_RegWrite;
        id_b.memread  = id_MemRead;
        id_b.memwrite = id_MemWrite;
        id_b.branch   = id_Branch;
        id_b.bne      = id_Bne;
        id_b.jump     = id_Jump;
        id_b.rs       = id_rs;
        id_b.rt       = id_rt;
        id_b.wreg     = id_RegDst ? id_rd : id_rt;
    end

    // A taken branch squashes the ID instruction anyway, so it overrides any stall.
    always_comb begin
        take   = ex_q.jump | (ex_q.branch & ex_zero) | (ex_q.bne & ~ex_zero);
        lu_hit = ex_q.memread & (ex_q.wreg != '0) &
                 ((ex_q.wreg == id_rs) | (ex_q.wreg == id_rt));
        stall  = (LU_STALL != 0) & id_valid & lu_hit & ~take;
        bubble = ~id_valid | stall | take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q           <= bubble ? '0 : id_b;
            mem_q.regwrite <= ex_q.regwrite;
            mem_q.memtoreg <= ex_q.memtoreg;
            mem_q.memread  <= ex_q.memread;
            mem_q.memwrite <= ex_q.memwrite;
            mem_q.wreg     <= ex_q.wreg;
            wb_q.regwrite  <= mem_q.regwrite;
            wb_q.memtoreg  <= mem_q.memtoreg;
            wb_q.wreg      <= mem_q.wreg;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input exmem_t m, input memwb_t w);
        if (m.regwrite && m.wreg != '0 && m.wreg == src)
            return 2'b10;
        else if (w.regwrite && w.wreg != '0 && w.wreg == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
        fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);
    end

    assign pc_write     = ~stall;
    assign ifid_write   = ~stall;
    assign ifid_flush   = take;
    assign pc_src       = take;
    assign pc_jump      = take & ex_q.jump;

    assign ex_ALUSrc    = ex_q.alusrc;
    assign ex_ALUOp     = ex_q.aluop;
    assign ex_wreg      = ex_q.wreg;
    assign mem_MemRead  = mem_q.memread;
    assign mem_MemWrite = mem_q.memwrite;
    assign wb_RegWrite  = wb_q.regwrite;
    assign wb_MemtoReg  = wb_q.memtoreg;
    assign wb_wreg      = wb_q.wreg;

endmodule
